fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with IF/ID register,
// one-bubble jump redirect and a timed drain before halt.
module fetch_ctrl #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] prog_end,
  input  logic       stall_req,
  input  logic [7:0] instr,
  output logic [7:0] pc_out,
  output logic [7:0] id_instr,
  output logic [7:0] id_pc,
  output logic       id_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  logic [7:0] pc_n;
  logic [7:0] id_instr_n;
  logic [7:0] id_pc_n;
  logic       id_valid_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       jump;
  logic [7:0] target;

  // Jumps resolve from the IF/ID register, so the redirect costs one bubble.
  assign jump   = id_valid && (id_instr[7:6] == 2'b11);
  assign target = id_pc + 8'd1 + {{2{id_instr[5]}}, id_instr[5:0]};

  always_comb begin
    state_n    = state;
    pc_n       = pc_out;
    id_instr_n = id_instr;
    id_pc_n    = id_pc;
    id_valid_n = id_valid;
    cnt_n      = cnt;
    unique case (state)
      IDLE, HALT: begin
        id_valid_n = 1'b0;
        if (start) begin
          pc_n    = RESET_PC;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!stall_req) begin
          if (jump) begin
            pc_n       = target;
            id_valid_n = 1'b0;
          end else if (pc_out == prog_end) begin
            id_valid_n = 1'b0;
            cnt_n      = DRAIN_LAST;
            state_n    = DRAIN;
          end else begin
            id_instr_n = instr;
            id_pc_n    = pc_out;
            id_valid_n = 1'b1;
            pc_n       = pc_out + 8'd1;
          end
        end
      end
      DRAIN: begin
        id_valid_n = 1'b0;
        if (!stall_req) begin
          if (cnt == 8'd0) begin
            state_n = HALT;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc_out   <= RESET_PC;
      id_instr <= 8'h00;
      id_pc    <= 8'h00;
      id_valid <= 1'b0;
      cnt      <= 8'h00;
    end else begin
      state    <= state_n;
      pc_out   <= pc_n;
      id_instr <= id_instr_n;
      id_pc    <= id_pc_n;
      id_valid <= id_valid_n;
      cnt      <= cnt_n;
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic,
// checked each cycle against a program-level fetch model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] prog_end;
  logic       stall_req;
  logic [7:0] instr;
  logic [7:0] pc_out;
  logic [7:0] id_instr;
  logic [7:0] id_pc;
  logic       id_valid;
  logic       busy;
  logic       done;

  logic       b_rst;
  logic       b_start;
  logic [7:0] b_prog_end;
  logic       b_stall;
  logic [7:0] b_instr;
  logic [7:0] b_pc_out;
  logic [7:0] b_id_instr;
  logic [7:0] b_id_pc;
  logic       b_id_valid;
  logic       b_busy;
  logic       b_done;

  logic [7:0] mem [256];
  int checks   = 0;
  int failures = 0;
  int seen[$];
  int b_seen[$];

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;
  int m_mode, m_pc, m_v, m_ii, m_ip, m_left;

  always #5 clk = ~clk;

  assign instr   = mem[pc_out];
  assign b_instr = 8'h00;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_end(prog_end), .stall_req(stall_req),
    .instr(instr), .pc_out(pc_out),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_valid(id_valid), .busy(busy), .done(done)
  );

  fetch_ctrl #(.RESET_PC(8'hFE)) dut2 (
    .clk(clk), .rst(b_rst), .start(b_start),
    .prog_end(b_prog_end), .stall_req(b_stall),
    .instr(b_instr), .pc_out(b_pc_out),
    .id_instr(b_id_instr), .id_pc(b_id_pc),
    .id_valid(b_id_valid), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Program-level view: a fetch pointer, the slot handed to decode,
  // and how many idle cycles remain before the halt.
  task automatic model_edge();
    int off;
    if (!rst) begin
      m_mode = M_IDLE; m_pc = 0; m_v = 0;
      m_ii = 0; m_ip = 0; m_left = 0;
      return;
    end
    if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (start) begin
        m_mode = M_RUN;
        m_pc   = 0;
      end
    end else if (stall_req) begin
      m_left = m_left;
    end else if (m_mode == M_DRAIN) begin
      m_left--;
      if (m_left == 0) m_mode = M_HALT;
    end else if (m_v != 0 && m_ii >= 192) begin
      off = m_ii % 64;
      if (off >= 32) off -= 64;
      m_pc = ((m_ip + 1 + off) % 256 + 256) % 256;
      m_v  = 0;
    end else if (m_pc == int'(prog_end)) begin
      m_v    = 0;
      m_left = 3;
      m_mode = M_DRAIN;
    end else begin
      m_ii = int'(mem[m_pc]);
      m_ip = m_pc;
      m_v  = 1;
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc_out", pc_out, m_pc);
    check("id_valid", id_valid, m_v);
    check("busy", busy,
          (m_mode == M_RUN || m_mode == M_DRAIN) ? 1 : 0);
    check("done", done, (m_mode == M_HALT) ? 1 : 0);
    if (m_v != 0) begin
      check("id_pc", id_pc, m_ip);
      check("id_instr", id_instr, m_ii);
    end
    if (id_valid === 1'b1) seen.push_back(int'(id_pc));
    if (b_id_valid === 1'b1) b_seen.push_back(int'(b_id_pc));
  endtask

  task automatic wait_done(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) break;
      step();
    end
    check(tag, done, 1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load_prog();
    clear_mem();
    mem[0] = 8'h1B; mem[1] = 8'h5A; mem[2] = 8'h53;
    mem[3] = 8'hC1; mem[4] = 8'h1C; mem[5] = 8'h5D;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic check_seq(input string tag);
    int exp[5] = '{0, 1, 2, 3, 5};
    check({tag, "_len"}, seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check(tag, seen[i], exp[i]);
  endtask

  initial begin
    int drain_n;
    rst = 1'b0; start = 1'b0; stall_req = 1'b0;
    prog_end = 8'd6;
    b_rst = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    b_prog_end = 8'h01;
    load_prog();

    step();
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_pc", pc_out, 0);
    rst = 1'b1;
    step();

    // Basic program: jump at 3 skips 4, then drain.
    seen.delete();
    start = 1'b1; step(); start = 1'b0;
    drain_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) break;
      step();
      if (busy && !id_valid && seen.size() == 5) drain_n++;
    end
    check("prog_done", done, 1);
    check_seq("prog_seq");
    check("drain_len", drain_n, 3);

    // Restart from HALT, then stall with the jump held in IF/ID.
    start = 1'b1; step(); start = 1'b0;
    check("restart_done", done, 0);
    step();
    check("restart_valid", id_valid, 1);
    check("restart_pc", id_pc, 0);
    for (int i = 0; i < 10; i++) begin
      if (id_valid && id_instr == 8'hC1) break;
      step();
    end
    check("reach_c1", id_instr, 8'hC1);
    stall_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc", pc_out, 4);
      check("stall_id_pc", id_pc, 3);
      check("stall_valid", id_valid, 1);
    end
    stall_req = 1'b0;
    step();
    check("unstall_pc", pc_out, 5);
    check("unstall_bubble", id_valid, 0);
    step();
    check("after_bubble", id_pc, 5);
    wait_done(20, "stall_done");

    // Mid-RUN reset, then identical rerun.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0; step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", id_valid, 0);
    check("mid_rst_pc", pc_out, 0);
    rst = 1'b1;
    seen.delete();
    start = 1'b1; step(); start = 1'b0;
    wait_done(30, "rerun_done");
    check_seq("rerun_seq");

    // Negative jump offset.
    do_reset();
    clear_mem();
    mem[2] = 8'hFE;
    prog_end = 8'h10;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (id_valid && id_pc == 8'h02) break;
      step();
    end
    step();
    check("jmp_back_pc", pc_out, 8'h01);

    // Jump target wraps past 0xFF.
    do_reset();
    clear_mem();
    mem[0] = 8'hFD;
    mem[8'hFE] = 8'hC3;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (id_valid && id_pc == 8'hFE) break;
      step();
    end
    check("reach_fe", id_pc, 8'hFE);
    step();
    check("jmp_wrap_pc", pc_out, 8'h02);

    // Empty program: prog_end equals the start address.
    do_reset();
    prog_end = 8'h00;
    seen.delete();
    start = 1'b1; step(); start = 1'b0;
    step();
    check("empty_drain", busy, 1);
    check("empty_valid", id_valid, 0);
    wait_done(10, "empty_done");
    check("empty_none", seen.size(), 0);

    // Alternate RESET_PC, straight-line code wrapping through 0.
    do_reset();
    step();
    b_rst = 1'b1;
    b_seen.delete();
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b_done === 1'b1) break;
      step();
    end
    check("wrap_done", b_done, 1);
    check("wrap_len", b_seen.size(), 3);
    if (b_seen.size() == 3) begin
      check("wrap_pc0", b_seen[0], 8'hFE);
      check("wrap_pc1", b_seen[1], 8'hFF);
      check("wrap_pc2", b_seen[2], 8'h00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    prog_end = 8'($urandom_range(0, 40));
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) != 0);
      start     = ($urandom_range(0, 14) == 0);
      stall_req = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 49) == 0)
        prog_end = 8'($urandom_range(0, 255));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
